// File: rtl/hazard_unit_seq.sv
// Pipeline hazard unit for the RV32 five-stage core: stall/flush controls, E-stage
// forwarding selects, multi-cycle load-use interlock, D-cache miss freeze, perf counters.
module hazard_unit_seq #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              CpuRst,
    input  logic              ICacheMiss,
    input  logic              DCacheMiss,
    input  logic              BranchE,
    input  logic              JalrE,
    input  logic              JalD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [1:0]        RegReadD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [1:0]        RegReadE,
    input  logic              MemToRegE,
    input  logic [2:0]        RegWriteM,
    input  logic [2:0]        RegWriteW,
    input  logic              CntClr,
    output logic              StallF,
    output logic              FlushF,
    output logic              StallD,
    output logic              FlushD,
    output logic              StallE,
    output logic              FlushE,
    output logic              StallM,
    output logic              FlushM,
    output logic              StallW,
    output logic              FlushW,
    output logic [1:0]        Forward1E,
    output logic [1:0]        Forward2E,
    output logic [CNT_W-1:0]  StallCycles,
    output logic [CNT_W-1:0]  FlushEvents
);

    localparam int unsigned LU_W = 2;
    localparam logic [LU_W-1:0] LU_INIT = LU_W'(LOAD_LAT - 1);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_LU    = 2'd1;
    localparam logic [1:0] S_DMISS = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       eff_state;
    logic [LU_W-1:0]  lu_cnt;
    logic [LU_W-1:0]  lu_cnt_nxt;
    logic             inc_stall;
    logic             inc_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic m_wr;
    logic w_wr;
    logic e_match;
    logic m_match;
    logic lu_hit;

    assign m_wr = (RegWriteM != 3'd0) && (RdM != '0);
    assign w_wr = (RegWriteW != 3'd0) && (RdW != '0);

    // Forwarding selects: M beats W, x0 never forwards
    always_comb begin
        Forward1E = 2'b00;
        Forward2E = 2'b00;
        if (FWD_EN && !CpuRst) begin
            if (RegReadE[1]) begin
                if (m_wr && (RdM == Rs1E))      Forward1E = 2'b10;
                else if (w_wr && (RdW == Rs1E)) Forward1E = 2'b01;
            end
            if (RegReadE[0]) begin
                if (m_wr && (RdM == Rs2E))      Forward2E = 2'b10;
                else if (w_wr && (RdW == Rs2E)) Forward2E = 2'b01;
            end
        end
    end

    // Without forwarding no E-stage write enable is visible, so a nonzero RdE is treated as a writer
    assign e_match = (RdE != '0) &&
                     ((RegReadD[1] && (Rs1D == RdE)) || (RegReadD[0] && (Rs2D == RdE)));
    assign m_match = m_wr &&
                     ((RegReadD[1] && (Rs1D == RdM)) || (RegReadD[0] && (Rs2D == RdM)));
    assign lu_hit  = (MemToRegE && e_match) || (!FWD_EN && (e_match || m_match));

    always_ff @(posedge clk or posedge CpuRst) begin
        if (CpuRst) begin
            state  <= S_RUN;
            lu_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_cnt_nxt;
        end
    end

    // Leaving DMISS resumes a pending bubble train in the same cycle the miss drops
    always_comb begin
        eff_state = state;
        if (state == S_DMISS) eff_state = (lu_cnt != '0) ? S_LU : S_RUN;

        state_nxt  = eff_state;
        lu_cnt_nxt = lu_cnt;
        inc_stall  = 1'b0;
        inc_flush  = 1'b0;
        StallF = 1'b0; FlushF = 1'b0;
        StallD = 1'b0; FlushD = 1'b0;
        StallE = 1'b0; FlushE = 1'b0;
        StallM = 1'b0; FlushM = 1'b0;
        StallW = 1'b0; FlushW = 1'b0;

        if (CpuRst) begin
            FlushF = 1'b1; FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1; FlushW = 1'b1;
            state_nxt  = S_RUN;
            lu_cnt_nxt = '0;
        end else if (DCacheMiss) begin
            StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1; StallW = 1'b1;
            state_nxt  = S_DMISS;
            lu_cnt_nxt = lu_cnt;
            inc_stall  = 1'b1;
        end else if (BranchE || JalrE) begin
            FlushD     = 1'b1;
            FlushE     = 1'b1;
            state_nxt  = S_RUN;
            lu_cnt_nxt = '0;
            inc_flush  = 1'b1;
        end else if (eff_state == S_LU) begin
            StallF     = 1'b1;
            StallD     = 1'b1;
            FlushE     = 1'b1;
            lu_cnt_nxt = lu_cnt - LU_W'(1);
            state_nxt  = (lu_cnt == LU_W'(1)) ? S_RUN : S_LU;
            inc_stall  = 1'b1;
        end else if (lu_hit) begin
            StallF     = 1'b1;
            StallD     = 1'b1;
            FlushE     = 1'b1;
            lu_cnt_nxt = LU_INIT;
            state_nxt  = (LU_INIT != '0) ? S_LU : S_RUN;
            inc_stall  = 1'b1;
        end else if (JalD) begin
            FlushD    = 1'b1;
            inc_flush = 1'b1;
        end else if (ICacheMiss) begin
            StallF    = 1'b1;
            FlushD    = 1'b1;
            inc_stall = 1'b1;
        end
    end

    // Saturating counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge CpuRst) begin
        if (CpuRst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (CntClr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (inc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (inc_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign StallCycles = stall_cnt;
    assign FlushEvents = flush_cnt;

endmodule

// File: tb/tb_hazard_unit_seq.sv
// Directed bench for hazard_unit_seq: two configurations share the stimulus and are checked
// every cycle against a bubble-count model, plus hand-computed literal expectations.
module tb_hazard_unit_seq;

    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic CpuRst, ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MemToRegE, CntClr;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] RegReadD, RegReadE;
    logic [2:0] RegWriteM, RegWriteW;

    logic sf_a, ff_a, sd_a, fd_a, se_a, fe_a, sm_a, fm_a, sw_a, fw_a;
    logic [1:0] f1_a, f2_a;
    logic [31:0] sc_a, fc_a;
    logic sf_b, ff_b, sd_b, fd_b, se_b, fe_b, sm_b, fm_b, sw_b, fw_b;
    logic [1:0] f1_b, f2_b;
    logic [3:0] sc_b, fc_b;

    int     pend_a, pend_b;
    longint m_sc_a, m_fc_a, m_sc_b, m_fc_b;
    int     passed, total;

    always #5 clk = ~clk;

    hazard_unit_seq #(.REG_AW(AW), .LOAD_LAT(3), .FWD_EN(1'b1), .CNT_W(32)) u_a (
        .clk(clk), .CpuRst(CpuRst), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
        .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegReadD(RegReadD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegReadE(RegReadE), .MemToRegE(MemToRegE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .CntClr(CntClr),
        .StallF(sf_a), .FlushF(ff_a), .StallD(sd_a), .FlushD(fd_a), .StallE(se_a),
        .FlushE(fe_a), .StallM(sm_a), .FlushM(fm_a), .StallW(sw_a), .FlushW(fw_a),
        .Forward1E(f1_a), .Forward2E(f2_a), .StallCycles(sc_a), .FlushEvents(fc_a)
    );

    hazard_unit_seq #(.REG_AW(AW), .LOAD_LAT(1), .FWD_EN(1'b0), .CNT_W(4)) u_b (
        .clk(clk), .CpuRst(CpuRst), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
        .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegReadD(RegReadD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegReadE(RegReadE), .MemToRegE(MemToRegE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .CntClr(CntClr),
        .StallF(sf_b), .FlushF(ff_b), .StallD(sd_b), .FlushD(fd_b), .StallE(se_b),
        .FlushE(fe_b), .StallM(sm_b), .FlushM(fm_b), .StallW(sw_b), .FlushW(fw_b),
        .Forward1E(f1_b), .Forward2E(f2_b), .StallCycles(sc_b), .FlushEvents(fc_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a D source depends on a nonzero destination
    function automatic logic reads_d(input logic [AW-1:0] rd);
        return (rd != '0) && ((RegReadD[1] && (Rs1D == rd)) || (RegReadD[0] && (Rs2D == rd)));
    endfunction

    function automatic logic hazard(input bit fwd);
        if (MemToRegE && reads_d(RdE)) return 1'b1;
        if (!fwd && (reads_d(RdE) || ((RegWriteM != 3'd0) && reads_d(RdM)))) return 1'b1;
        return 1'b0;
    endfunction

    // Bit order: StallF FlushF StallD FlushD StallE FlushE StallM FlushM StallW FlushW
    function automatic logic [9:0] exp_ctl(input int pend, input bit fwd);
        if (CpuRst)             return 10'b01_01_01_01_01;
        if (DCacheMiss)         return 10'b10_10_10_10_10;
        if (BranchE || JalrE)   return 10'b00_01_01_00_00;
        if (pend > 0 || hazard(fwd)) return 10'b10_10_01_00_00;
        if (JalD)               return 10'b00_01_00_00_00;
        if (ICacheMiss)         return 10'b10_01_00_00_00;
        return 10'b0;
    endfunction

    function automatic logic [1:0] exp_fwd(input bit fwd, input logic used, input logic [AW-1:0] rs);
        if (CpuRst || !fwd || !used) return 2'b00;
        if ((RegWriteM != 3'd0) && (RdM != '0) && (RdM == rs)) return 2'b10;
        if ((RegWriteW != 3'd0) && (RdW != '0) && (RdW == rs)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic advance(input int lat, input bit fwd, input longint cmax,
                           inout int pend, inout longint sc, inout longint fc);
        bit st, fl;
        st = 1'b0;
        fl = 1'b0;
        if (CpuRst) begin
            pend = 0; sc = 0; fc = 0;
            return;
        end
        if (DCacheMiss) st = 1'b1;
        else if (BranchE || JalrE) begin pend = 0; fl = 1'b1; end
        else if (pend > 0) begin pend--; st = 1'b1; end
        else if (hazard(fwd)) begin pend = lat - 1; st = 1'b1; end
        else if (JalD) fl = 1'b1;
        else if (ICacheMiss) st = 1'b1;
        if (CntClr) begin
            sc = 0; fc = 0;
        end else begin
            if (st && sc < cmax) sc++;
            if (fl && fc < cmax) fc++;
        end
    endtask

    // One cycle: compare both DUTs against the model mid-cycle, then advance the model
    task automatic step();
        @(negedge clk);
        chk("ctl_a", 64'({sf_a, ff_a, sd_a, fd_a, se_a, fe_a, sm_a, fm_a, sw_a, fw_a}), 64'(exp_ctl(pend_a, 1'b1)));
        chk("fwd1_a", 64'(f1_a), 64'(exp_fwd(1'b1, RegReadE[1], Rs1E)));
        chk("fwd2_a", 64'(f2_a), 64'(exp_fwd(1'b1, RegReadE[0], Rs2E)));
        chk("stall_cnt_a", 64'(sc_a), 64'(m_sc_a));
        chk("flush_cnt_a", 64'(fc_a), 64'(m_fc_a));
        chk("ctl_b", 64'({sf_b, ff_b, sd_b, fd_b, se_b, fe_b, sm_b, fm_b, sw_b, fw_b}), 64'(exp_ctl(pend_b, 1'b0)));
        chk("fwd1_b", 64'(f1_b), 64'(exp_fwd(1'b0, RegReadE[1], Rs1E)));
        chk("fwd2_b", 64'(f2_b), 64'(exp_fwd(1'b0, RegReadE[0], Rs2E)));
        chk("stall_cnt_b", 64'(sc_b), 64'(m_sc_b));
        chk("flush_cnt_b", 64'(fc_b), 64'(m_fc_b));
        advance(3, 1'b1, 64'hFFFF_FFFF, pend_a, m_sc_a, m_fc_a);
        advance(1, 1'b0, 64'hF, pend_b, m_sc_b, m_fc_b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ICacheMiss = 0; DCacheMiss = 0; BranchE = 0; JalrE = 0; JalD = 0;
        MemToRegE = 0; CntClr = 0;
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegReadD = 2'b00; RegReadE = 2'b00; RegWriteM = 3'd0; RegWriteW = 3'd0;
    endtask

    task automatic clear_counters();
        idle();
        CntClr = 1;
        step();
        CntClr = 0;
    endtask

    initial begin
        logic [3:0] vec [5];
        passed = 0; total = 0;
        pend_a = 0; pend_b = 0;
        m_sc_a = 0; m_fc_a = 0; m_sc_b = 0; m_fc_b = 0;
        vec[0] = 4'b0010; vec[1] = 4'b0001; vec[2] = 4'b0011; vec[3] = 4'b0100; vec[4] = 4'b1000;

        // Reset state
        CpuRst = 1;
        idle();
        #1;
        chk("rst_flushF", 64'(ff_a), 64'(1));
        chk("rst_stallF", 64'(sf_a), 64'(0));
        chk("rst_cnt", 64'(sc_a), 64'(0));
        step();
        step();
        CpuRst = 0;

        // Forwarding priority
        RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1; RegReadE = 2'b10;
        #1 chk("fwd_m_prio", 64'(f1_a), 64'(2'b10));
        step();
        RegWriteM = 0;
        #1 chk("fwd_w", 64'(f1_a), 64'(2'b01));
        step();
        Rs1E = 0;
        #1 chk("fwd_x0", 64'(f1_a), 64'(2'b00));
        step();
        Rs2E = 5; RegReadE = 2'b11; RegWriteM = 2; RdW = 9;
        step();

        // Load-use, three bubbles
        clear_counters();
        MemToRegE = 1; RdE = 7; Rs2D = 7; RegReadD = 2'b01;
        #1 chk("lu_b1_stallF", 64'(sf_a), 64'(1));
        step();
        MemToRegE = 0; RdE = 0;
        step();
        step();
        #1 chk("lu_done_stallF", 64'(sf_a), 64'(0));
        chk("lu_cnt3", 64'(sc_a), 64'(3));
        step();

        // D-cache miss in the middle of the bubble train
        clear_counters();
        MemToRegE = 1; RdE = 7; Rs2D = 7; RegReadD = 2'b01;
        step();
        MemToRegE = 0; RdE = 0;
        step();
        DCacheMiss = 1;
        #1 chk("dmiss_stallW", 64'(sw_a), 64'(1));
        for (int i = 0; i < 4; i++) step();
        DCacheMiss = 0;
        #1 chk("dmiss_resume", 64'({sf_a, fe_a, sw_a}), 64'(3'b110));
        step();
        #1 chk("dmiss_after", 64'(sf_a), 64'(0));
        chk("dmiss_cnt", 64'(sc_a), 64'(7));
        step();

        // Redirect beats I-miss and load-use
        clear_counters();
        BranchE = 1; ICacheMiss = 1; MemToRegE = 1; RdE = 7; Rs2D = 7; RegReadD = 2'b01;
        #1 chk("br_ctl", 64'({sf_a, fd_a, fe_a}), 64'(3'b011));
        step();
        idle();
        #1 chk("br_no_train", 64'(sf_a), 64'(0));
        chk("br_events", 64'(fc_a), 64'(1));
        step();

        // Async reset pulse mid bubble train
        MemToRegE = 1; RdE = 7; Rs2D = 7; RegReadD = 2'b01;
        step();
        idle();
        CpuRst = 1;
        #1;
        chk("arst_flush", 64'({ff_a, fd_a, fe_a, fm_a, fw_a}), 64'(5'b11111));
        chk("arst_stall", 64'(sf_a), 64'(0));
        chk("arst_cnt", 64'(sc_a), 64'(0));
        pend_a = 0; pend_b = 0;
        m_sc_a = 0; m_fc_a = 0; m_sc_b = 0; m_fc_b = 0;
        #1 CpuRst = 0;
        step();
        chk("arst_run", 64'(sf_a), 64'(0));
        chk("arst_cnt_after", 64'(sc_a), 64'(0));

        // No forwarding: M-stage dependency stalls instead
        RdM = 3; RegWriteM = 1; Rs1D = 3; RegReadD = 2'b10; Rs1E = 3; RegReadE = 2'b10;
        #1 chk("nofwd_stall", 64'(sf_b), 64'(1));
        chk("nofwd_fwd", 64'(f1_b), 64'(0));
        chk("fwd_cfg_fwd", 64'(f1_a), 64'(2'b10));
        step();

        // Counter saturation and clear priority
        clear_counters();
        DCacheMiss = 1;
        for (int i = 0; i < 20; i++) step();
        chk("sat_b", 64'(sc_b), 64'(4'hF));
        chk("nosat_a", 64'(sc_a), 64'(20));
        CntClr = 1;
        step();
        chk("clr_prio", 64'(sc_b), 64'(0));
        idle();
        step();

        // Lower-priority controls in isolation and combination
        foreach (vec[i]) begin
            idle();
            {BranchE, JalrE, JalD, ICacheMiss} = vec[i];
            step();
        end
        idle();
        step();
        chk("final_flush_events", 64'(fc_a), 64'(4));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
